// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// The system side drives the word and its framing options. The
// transmitter drives the line and the busy flag back.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] P_DATA;      // word to send
   logic                  DATA_VALID;  // one-cycle strobe qualifying P_DATA/PAR_EN/PAR_TYP
   logic                  PAR_EN;      // 1 = append a parity bit
   logic                  PAR_TYP;     // 0 = even, 1 = odd
   logic                  TX_OUT;      // serial line, idle high
   logic                  Busy;        // high while a frame is on TX_OUT

   // System / FIFO side: supplies words and watches the line.
   modport master (
      output P_DATA,
      output DATA_VALID,
      output PAR_EN,
      output PAR_TYP,
      input  TX_OUT,
      input  Busy
   );

   // Transmitter side: consumes words and drives the line.
   modport slave (
      input  P_DATA,
      input  DATA_VALID,
      input  PAR_EN,
      input  PAR_TYP,
      output TX_OUT,
      output Busy
   );

endinterface : uart_tx_if

// File: rtl/uart_tx_top.sv
// UART transmitter core. CLK is already the bit clock, so the core sends
// one bit per cycle. A frame is: start (0), DATA_WIDTH data bits sent LSB
// first, an optional parity bit, and stop (1). The word and its options
// are captured on the accepting edge. A strobe that arrives mid-frame is
// ignored. The line value and Busy come straight from flops, so TX_OUT
// lags the FSM state by one edge.
module uart_tx_top #(
   parameter int DATA_WIDTH = 8
) (
   input  logic      CLK,
   input  logic      RST,     // asynchronous, active low
   uart_tx_if.slave  bus
);

   // Counter width covering 0..DATA_WIDTH-1.
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e                state_q,   state_d;
   logic [DATA_WIDTH-1:0] data_q,    data_d;
   logic                  par_en_q,  par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  tx_q,      tx_d;
   logic                  busy_q,    busy_d;

   logic                  par_bit;
   logic                  mux_bit;

   // State, capture registers and bit counter.
   // NOTE: the whole datapath is a few flops, not a memory array, so every
   // register gets an async reset. The line is idle and the word is clean
   // straight out of reset or after a reset in the middle of a frame.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         // NOTE: use non-blocking assignments for every flop. All registers
         // then update together from values sampled before the edge.
         state_q   <= state_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Next-state logic. Capture happens only in IDLE, which makes any
   // mid-frame strobe or input change invisible to the current frame.
   always_comb begin
      // NOTE: give every output a hold value first. Each branch then only
      // overrides what changes, and no path can infer a latch.
      state_d   = state_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      bit_cnt_d = bit_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.DATA_VALID) begin
               data_d    = bus.P_DATA;
               par_en_d  = bus.PAR_EN;
               par_typ_d = bus.PAR_TYP;
               bit_cnt_d = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
         end
         S_DATA: begin
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               state_d   = par_en_q ? S_PARITY : S_STOP;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            state_d = S_STOP;
         end
         S_STOP: begin
            // Return to IDLE. No new word is accepted directly from STOP.
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
         end
      endcase
   end

   // Parity of the captured word. Even parity is the plain XOR. Odd
   // parity is its complement.
   always_comb begin
      par_bit = par_typ_q ? ~(^data_q) : (^data_q);
   end

   // Output mux: the line value belonging to the current state.
   always_comb begin
      mux_bit = 1'b1;
      unique case (state_q)
         S_IDLE:   mux_bit = 1'b1;
         S_START:  mux_bit = 1'b0;
         S_DATA:   mux_bit = data_q[bit_cnt_q];
         S_PARITY: mux_bit = par_bit;
         S_STOP:   mux_bit = 1'b1;
         default:  mux_bit = 1'b1;
      endcase
   end

   // Next values for the output stage. Busy covers every state that puts
   // a frame bit on the line.
   always_comb begin
      tx_d   = mux_bit;
      busy_d = (state_q != S_IDLE);
   end

   // Registered output stage. Reset forces the line idle immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= busy_d;
      end
   end

   assign bus.TX_OUT = tx_q;
   assign bus.Busy   = busy_q;

endmodule : uart_tx_top

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top. Each accepted word is turned into
// its expected frame (start, LSB-first data, optional parity, stop). The
// line and Busy are then compared cycle by cycle after each rising edge.
module tb_uart_tx_top;

   localparam int DW = 8;

   logic CLK;
   logic RST;
   int   total;
   int   bad;

   uart_tx_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_top #(.DATA_WIDTH(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Build the expected frame for a word from the framing rules.
   function automatic void build_frame(input logic [DW-1:0] data, input logic pe,
                                       input logic pt, output logic frame[$]);
      int ones;
      frame = {};
      frame.push_back(1'b0);
      ones = 0;
      for (int k = 0; k < DW; k++) begin
         frame.push_back(data[k]);
         if (data[k]) ones++;
      end
      if (pe) begin
         // Even parity: the bit makes the total count of ones even.
         // Odd parity: the bit makes the total count odd.
         if (pt == 1'b0) frame.push_back(logic'(ones % 2));
         else            frame.push_back(logic'((ones + 1) % 2));
      end
      frame.push_back(1'b1);
   endfunction

   // Check the idle line for n cycles while keeping DATA_VALID low.
   task automatic idle_cycles(input int n, input string tag, input bit scramble);
      for (int i = 0; i < n; i++) begin
         if (scramble) begin
            bus.P_DATA  = DW'($urandom);
            bus.PAR_EN  = 1'($urandom);
            bus.PAR_TYP = 1'($urandom);
         end
         @(posedge CLK);
         #1;
         check($sformatf("%s_tx%0d", tag, i), 32'(bus.TX_OUT), 32'd1);
         check($sformatf("%s_busy%0d", tag, i), 32'(bus.Busy), 32'd0);
      end
   endtask

   // Send one word and follow it through to idle.
   // inject_at>0: strobe 8'hFF so that it is sampled at edge E(inject_at).
   // abort_at>0: pull reset low just after edge E(abort_at) and stop following.
   task automatic run_frame(input string tag, input logic [DW-1:0] data, input logic pe,
                            input logic pt, input int inject_at, input int abort_at);
      logic frame[$];
      int   len;
      build_frame(data, pe, pt, frame);
      len = frame.size();

      @(negedge CLK);
      bus.P_DATA     = data;
      bus.PAR_EN     = pe;
      bus.PAR_TYP    = pt;
      bus.DATA_VALID = 1'b1;
      @(posedge CLK);              // E0: word accepted
      #1;
      bus.DATA_VALID = 1'b0;
      bus.P_DATA     = DW'($urandom);
      bus.PAR_EN     = 1'($urandom);
      bus.PAR_TYP    = 1'($urandom);

      for (int i = 1; i <= len + 1; i++) begin
         if (inject_at == i) begin
            bus.P_DATA     = '1;
            bus.DATA_VALID = 1'b1;
         end
         @(posedge CLK);
         #1;
         bus.DATA_VALID = 1'b0;
         if (i <= len) begin
            check($sformatf("%s_tx_E%0d", tag, i), 32'(bus.TX_OUT), 32'(frame[i-1]));
            check($sformatf("%s_busy_E%0d", tag, i), 32'(bus.Busy), 32'd1);
         end else begin
            check($sformatf("%s_tx_idle", tag), 32'(bus.TX_OUT), 32'd1);
            check($sformatf("%s_busy_idle", tag), 32'(bus.Busy), 32'd0);
         end
         if (abort_at == i) begin
            #1;
            RST = 1'b0;
            #1;
            check($sformatf("%s_rst_tx", tag), 32'(bus.TX_OUT), 32'd1);
            check($sformatf("%s_rst_busy", tag), 32'(bus.Busy), 32'd0);
            return;
         end
      end
   endtask

   initial begin
      logic [DW-1:0] w;
      logic          pt;
      total = 0;
      bad   = 0;

      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;

      // Reset held for 20 ns.
      RST = 1'b0;
      #12;
      check("reset_tx", 32'(bus.TX_OUT), 32'd1);
      check("reset_busy", 32'(bus.Busy), 32'd0);
      #8;
      RST = 1'b1;
      idle_cycles(4, "post_reset", 1'b0);

      // Directed frames.
      run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 0, 0);
      idle_cycles(2, "gap1", 1'b0);
      run_frame("81_odd", 8'h81, 1'b1, 1'b1, 0, 0);
      idle_cycles(2, "gap2", 1'b0);
      run_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, 0, 0);
      idle_cycles(2, "gap3", 1'b0);

      // A strobe in the middle of a frame must be ignored.
      pt = 1'($urandom);
      run_frame("mid_strobe", 8'h00, 1'b1, pt, 4, 0);
      idle_cycles(5, "no_second", 1'b0);

      // Reset during data bit 3, then a clean frame.
      run_frame("abort", 8'h55, 1'b1, 1'b0, 0, 5);
      @(negedge CLK);
      check("abort_hold_tx", 32'(bus.TX_OUT), 32'd1);
      check("abort_hold_busy", 32'(bus.Busy), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      idle_cycles(2, "abort_rel", 1'b0);
      run_frame("after_abort", 8'hC3, 1'b1, 1'b1, 0, 0);
      idle_cycles(2, "gap4", 1'b0);

      // Random words, with and without parity, 60 ns gaps.
      for (int n = 0; n < 20; n++) begin
         w  = DW'($urandom);
         pt = 1'($urandom);
         run_frame($sformatf("rnd%0d", n), w, (n < 10), pt, 0, 0);
         idle_cycles(6, $sformatf("rnd_gap%0d", n), 1'b0);
      end

      // Option inputs toggling with no strobe have no effect.
      idle_cycles(20, "no_strobe", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_tx_top
